// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: round-robin owner of one shared parallel-in/serial-out
// shifter. It grants one requester, captures that requester's word and
// shifts it out MSB first with sval/sfirst framing. It then holds the link
// idle for GAP cycles before it arbitrates again.
//
// Handshake (req/gnt): a requester raises req with its word on data and
// holds both steady. The word is captured at the edge after which gnt pulses
// for one cycle. The requester must drop req, or present its next word, at
// the edge that follows the cycle in which it sees gnt. req is only looked at
// on decision edges, so changes between them have no effect.
module piso_tx_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    sout,
  output logic                    sval,
  output logic                    sfirst,
  output logic [$clog2(NREQ)-1:0] src,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [SW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              sval_q, sval_d;
  logic              sfirst_q, sfirst_d;
  logic [SW-1:0]     src_q, src_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic [SW-1:0]     pick_idx;
  logic [SW-1:0]     cand;
  logic [WIDTH-1:0]  pick_word;
  logic              decide;

  // Round-robin pick: first asserted req starting just after the last grant.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = SW'((int'(last_q) + i) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_word = data[pick_idx*WIDTH +: WIDTH];
  end

  // Next-state logic: shift or count down the gap, and arbitrate on decision edges.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    gnt_d     = '0;
    sval_d    = sval_q;
    sfirst_d  = 1'b0;
    src_d     = src_q;
    decide    = 1'b0;

    case (state_q)
      S_IDLE: decide = 1'b1;
      S_SHIFT: begin
        // The shifter fills with zeros, so it is all-zero once a frame ends
        // and sout stays low outside frames without extra gating.
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GW'(GAP - 1);
            sval_d    = 1'b0;
          end else begin
            decide = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          decide = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      if (pick_valid) begin
        state_d         = S_SHIFT;
        shreg_d         = pick_word;
        bit_cnt_d       = CW'(WIDTH - 1);
        gnt_d[pick_idx] = 1'b1;
        src_d           = pick_idx;
        last_d          = pick_idx;
        sval_d          = 1'b1;
        sfirst_d        = 1'b1;
      end else begin
        state_d = S_IDLE;
        sval_d  = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; clear aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= SW'(NREQ - 1);
      gnt_q     <= '0;
      sval_q    <= 1'b0;
      sfirst_q  <= 1'b0;
      src_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sval_q    <= sval_d;
      sfirst_q  <= sfirst_d;
      src_q     <= src_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign sout      = shreg_q[WIDTH-1];
  assign sval      = sval_q;
  assign sfirst    = sfirst_q;
  assign src       = src_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: one instance with GAP=1 and one with GAP=0,
// both checked every cycle against a frame-position model, plus directed
// scenarios with literal expectations.
module tb_piso_tx_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int SW   = 2;
  localparam int NI   = 2;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            sout;
    logic            sval;
    logic            sfirst;
    logic [SW-1:0]   src;
    logic            busy;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clear_s [NI];
  logic [NREQ-1:0]   req_s   [NI];
  logic [NREQ*W-1:0] data_s  [NI];
  logic [NREQ-1:0]   gnt_o   [NI];
  logic              sout_o  [NI];
  logic              sval_o  [NI];
  logic              sfirst_o[NI];
  logic [SW-1:0]     src_o   [NI];
  logic              busy_o  [NI];
  logic [1:0]        st_o    [NI];

  piso_tx_scheduler #(.NREQ(NREQ), .WIDTH(W), .GAP(1)) dut_g1 (
    .clk(clk), .clear(clear_s[0]), .req(req_s[0]), .data(data_s[0]),
    .gnt(gnt_o[0]), .sout(sout_o[0]), .sval(sval_o[0]), .sfirst(sfirst_o[0]),
    .src(src_o[0]), .busy(busy_o[0]), .dbg_state(st_o[0])
  );

  piso_tx_scheduler #(.NREQ(NREQ), .WIDTH(W), .GAP(0)) dut_g0 (
    .clk(clk), .clear(clear_s[1]), .req(req_s[1]), .data(data_s[1]),
    .gnt(gnt_o[1]), .sout(sout_o[1]), .sval(sval_o[1]), .sfirst(sfirst_o[1]),
    .src(src_o[1]), .busy(busy_o[1]), .dbg_state(st_o[1])
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is WIDTH bit cycles followed by gap cycles; m_pos counts cycles
  // since the grant, and arbitration happens when idle or on the last cycle.
  bit         m_act [NI];
  int         m_pos [NI];
  logic [W-1:0] m_word[NI];
  int         m_src [NI];
  int         m_last[NI];

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int i);
    int k;
    if (clear_s[i]) begin
      m_act[i]  = 1'b0;
      m_src[i]  = 0;
      m_last[i] = NREQ - 1;
    end else if (!m_act[i] || m_pos[i] == W + gap_of(i) - 1) begin
      k = -1;
      for (int s = 1; s <= NREQ; s++)
        if (k < 0 && req_s[i][(m_last[i] + s) % NREQ]) k = (m_last[i] + s) % NREQ;
      if (k >= 0) begin
        m_act[i]  = 1'b1;
        m_pos[i]  = 0;
        m_word[i] = data_s[i][k*W +: W];
        m_src[i]  = k;
        m_last[i] = k;
      end else begin
        m_act[i] = 1'b0;
      end
    end else begin
      m_pos[i]++;
    end
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o = '0;
    o.src = SW'(m_src[i]);
    if (m_act[i]) begin
      o.busy = 1'b1;
      if (m_pos[i] < W) begin
        o.sval   = 1'b1;
        o.sout   = m_word[i][W-1-m_pos[i]];
        o.sfirst = (m_pos[i] == 0);
        if (m_pos[i] == 0) o.gnt[m_src[i]] = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) model_step(i);
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    obs_t e;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        e = model_obs(i);
        chk("gnt",    i, 32'(gnt_o[i]),    32'(e.gnt));
        chk("sout",   i, 32'(sout_o[i]),   32'(e.sout));
        chk("sval",   i, 32'(sval_o[i]),   32'(e.sval));
        chk("sfirst", i, 32'(sfirst_o[i]), 32'(e.sfirst));
        chk("src",    i, 32'(src_o[i]),    32'(e.src));
        chk("busy",   i, 32'(busy_o[i]),   32'(e.busy));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int g_log[NI][16];
  int g_n  [NI];

  task automatic pulse_clear(input logic [NI-1:0] mask);
    for (int i = 0; i < NI; i++) if (mask[i]) clear_s[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) clear_s[i] = 1'b0;
  endtask

  // Requesters drop req after their grant; wait until both links are idle.
  task automatic drain();
    bit   done;
    obs_t o;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        o = model_obs(i);
        if (o.gnt != '0) begin
          if (g_n[i] < 16) g_log[i][g_n[i]] = m_src[i];
          g_n[i]++;
          req_s[i][m_src[i]] = 1'b0;
        end
        if (m_act[i] || req_s[i] != '0) done = 1'b0;
      end
    end
    chk("drain_done", 0, 32'(done), 32'd1);
  endtask

  task automatic rand_drive();
    obs_t o;
    for (int i = 0; i < NI; i++) begin
      o = model_obs(i);
      clear_s[i] = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NREQ; k++) begin
        if (o.gnt[k]) begin
          if ($urandom_range(0, 1) == 0) req_s[i][k] = 1'b0;
          else data_s[i][k*W +: W] = W'($urandom);
        end else if (!req_s[i][k] && $urandom_range(0, 3) == 0) begin
          req_s[i][k] = 1'b1;
          data_s[i][k*W +: W] = W'($urandom);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] lv_sval   = 6'b111100;
  logic [5:0] lv_sout   = 6'b101000;
  logic [5:0] lv_busy   = 6'b111110;
  logic [5:0] lv_sfirst = 6'b100000;
  int         e3_order[5] = '{0, 1, 2, 3, 0};
  int         e4_order[2] = '{0, 2};

  initial begin
    int ord[5];
    int cyc[5];
    int cnt;
    int idx;

    for (int i = 0; i < NI; i++) begin
      clear_s[i] = 1'b1;
      req_s[i]   = '0;
      data_s[i]  = '0;
      g_n[i]     = 0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset with all requesters active.
    for (int i = 0; i < NI; i++) req_s[i] = '1;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("rst_gnt",  i, 32'(gnt_o[i]),  32'd0);
        chk("rst_sval", i, 32'(sval_o[i]), 32'd0);
        chk("rst_sout", i, 32'(sout_o[i]), 32'd0);
        chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
      end
    end
    for (int i = 0; i < NI; i++) clear_s[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("rst_first_gnt", i, 32'(gnt_o[i]), 32'h1);
    drain();

    // Single request 1010 on the GAP=1 link.
    req_s[0] = 4'b0001;
    data_s[0][3:0] = 4'b1010;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("t2_sval",   0, 32'(sval_o[0]),   32'(lv_sval[5-j]));
      chk("t2_sout",   0, 32'(sout_o[0]),   32'(lv_sout[5-j]));
      chk("t2_busy",   0, 32'(busy_o[0]),   32'(lv_busy[5-j]));
      chk("t2_sfirst", 0, 32'(sfirst_o[0]), 32'(lv_sfirst[5-j]));
      if (j == 0) begin
        chk("t2_gnt", 0, 32'(gnt_o[0]), 32'h1);
        chk("t2_src", 0, 32'(src_o[0]), 32'd0);
        req_s[0] = '0;
      end
    end

    // Sparse requests from 0 and 2 after a fresh reset.
    pulse_clear(2'b01);
    req_s[0] = 4'b0101;
    data_s[0] = {4'b0000, 4'b0011, 4'b0000, 4'b1100};
    g_n[0] = 0;
    drain();
    chk("t4_count", 0, 32'(g_n[0]), 32'd2);
    for (int j = 0; j < 2; j++) chk("t4_order", 0, 32'(g_log[0][j]), 32'(e4_order[j]));

    // All requesting and held: rotation 0,1,2,3,0 spaced WIDTH+GAP apart.
    pulse_clear(2'b01);
    req_s[0] = 4'b1111;
    data_s[0] = {4'b0001, 4'b1111, 4'b0110, 4'b1001};
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 5; c++) begin
      @(negedge clk);
      idx = onehot_idx(gnt_o[0]);
      if (idx >= 0) begin
        ord[cnt] = idx;
        cyc[cnt] = c;
        cnt++;
      end
    end
    chk("t3_count", 0, 32'(cnt), 32'd5);
    for (int j = 0; j < cnt; j++) begin
      chk("t3_order", 0, 32'(ord[j]), 32'(e3_order[j]));
      if (j > 0) chk("t3_spacing", 0, 32'(cyc[j] - cyc[j-1]), 32'(W + 1));
    end
    req_s[0] = '0;
    drain();

    // Abort after two bits, then pointer is back at requester 0.
    req_s[0] = 4'b0001;
    data_s[0][3:0] = 4'b1010;
    @(negedge clk);
    chk("t5_bit0", 0, 32'(sout_o[0]), 32'd1);
    req_s[0] = '0;
    @(negedge clk);
    chk("t5_bit1", 0, 32'(sout_o[0]), 32'd0);
    clear_s[0] = 1'b1;
    @(negedge clk);
    chk("t5_abort_sval", 0, 32'(sval_o[0]), 32'd0);
    chk("t5_abort_busy", 0, 32'(busy_o[0]), 32'd0);
    clear_s[0] = 1'b0;
    req_s[0] = 4'b0011;
    data_s[0][7:0] = 8'b0110_1001;
    @(negedge clk);
    chk("t5_regrant", 0, 32'(gnt_o[0]), 32'h1);
    req_s[0][0] = 1'b0;
    drain();

    // Back-to-back frames on the GAP=0 link.
    pulse_clear(2'b10);
    req_s[1] = 4'b0011;
    data_s[1][7:0] = 8'b0101_1100;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("t6_sval",   1, 32'(sval_o[1]),   32'd1);
      chk("t6_sfirst", 1, 32'(sfirst_o[1]), 32'((j % 4) == 0));
      chk("t6_src",    1, 32'(src_o[1]),    32'((j / 4) % 2));
    end
    req_s[1] = '0;
    drain();

    // Randomized traffic with occasional aborts on both links.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_drive();
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) clear_s[i] = 1'b0;
    drain();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
- Round-robin scheduler that shares one 4-bit parallel-in/serial-out shifter between NREQ requesters.
- Grants one requester at a time, captures its word, shifts it out MSB first with framing strobes, then enforces an inter-frame gap.
- Sits between word producers and a single-wire serial link.
- Sequences the load/shift of the shared shifter so producers never drive the load strobe directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, bits per word (>=2).
- GAP, 1, minimum idle cycles between frames (0..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clear  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; held with data until granted.
- data  in  NREQ*WIDTH  word per requester, requester k at bits [k*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, one-cycle pulse: word of requester k captured.
- sout  out  1  serial data, MSB first; 0 when sval=0.
- sval  out  1  high for exactly WIDTH consecutive cycles per frame.
- sfirst  out  1  high with the first (MSB) bit of each frame.
- src  out  $clog2(NREQ)  index of the requester owning the current frame; holds after the frame ends.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, SHIFT, GAP. All outputs registered.
- Reset: clear=1 at an edge gives state=IDLE; gnt, sout, sval, sfirst, src, busy all 0; shifter 0; counters 0; last-grant pointer set to NREQ-1, so requester 0 has top priority first.
- clear overrides everything, including mid-frame: the frame is aborted, sval=0 from the next cycle, and no residual bits are emitted.
- Decision edges, where arbitration happens:
  - any edge in IDLE;
  - the edge leaving SHIFT on the last bit when GAP=0;
  - the edge leaving GAP when the gap counter reaches 0.
- At a decision edge with req != 0:
  - k = first set req bit searching from (last+1) mod NREQ upward, wrapping.
  - gnt <= onehot(k); src <= k; last <= k.
  - shifter <= data slice k; bit counter <= WIDTH-1; state <= SHIFT.
  - sfirst=1 and sval=1 in the following cycle.
- At a decision edge with req = 0: state <= IDLE, sval <= 0.
- Latency: request sampled at edge E0; gnt, sval, sfirst and the MSB are all visible in cycle E0+1.
- SHIFT:
  - sout = shifter MSB.
  - Each edge shifts left, fills 0, and decrements the counter.
  - sfirst is high only in the first SHIFT cycle.
  - After the cycle with counter=0: go to GAP with gap counter=GAP-1 if GAP>0; otherwise take the decision edge.
- GAP: sval=0, sout=0, busy=1; decrement each edge; the edge at 0 is a decision edge.
- With GAP=0, frames are back-to-back with no dead cycle.
- Requester rule: deassert req (or present a new word) at the edge after gnt is seen. WIDTH>=2 guarantees this precedes the next decision edge, so a word is never sent twice.
- req changes outside decision edges are ignored. data is sampled only at the granting edge.
- Simultaneous requests are resolved only by the round-robin pointer. A requester that stays asserted waits at most NREQ-1 frames.

Test Plan:
1. Reset: clear=1 for 2 cycles with req=1111 -> gnt=0, sval=0, sout=0, busy=0 throughout; after release, first grant goes to requester 0.
2. Single request, GAP=1: req=0001, data0=1010 -> gnt=0001 for one cycle; sout 1,0,1,0 with sval=1 for 4 cycles, sfirst only on the first; src=0; then 1 idle cycle with busy=1, then IDLE.
3. All requesting: req=1111 held, words 1001/0110/1111/0001 -> grant order 0,1,2,3,0. Each frame emits its word. Frames are separated by exactly GAP cycles.
4. Sparse requests: req=0101, data0=1100, data2=0011, each requester drops req after its gnt -> frames 1100 then 0011, src 0 then 2; requester 2 then releases and the block returns to IDLE.
5. Abort: clear=1 after 2 bits of a frame with data 1010 -> sval=0 next cycle, no further bits; pointer reset, so a following req=0011 grants requester 0 first.
6. Back-to-back: GAP=0, req=0011 held -> sval continuously high across frames, sfirst every 4th cycle, src alternating 0,1.
